difference_map_engine: RTL and testbench
========================================

Name: difference_map_engine

Overview:
- Sequential executor for one differenceMap_a descriptor against the exe-env u32 word store: mem[origin+i] = mem[origin+i] - mem[modifier+i] for i in 0..length-1.
- Sits downstream of the instruction decoder, which packs differenceMap_a; replaces the whole-state combinational function with a one-word-per-cycle pipeline on a 2R1W word store.
- Preserves snapshot semantics: every read sees the pre-operation value.

Parameters:
- ADDR_W, 8, word address width; store depth = 2**ADDR_W.
- DATA_W, 32, word width.
- NUM_FLAGS, 8, number of condition flags.
- SEL_W, 4, condition-select width; select value all-ones (COND_ALWAYS) = unconditional.

Ports:
- clk in 1 clock
- rst_n in 1 async active-low reset
- cmd_valid in 1 descriptor offered
- cmd_ready out 1 engine idle, accepts descriptor
- cmd_origin in ADDR_W origin base
- cmd_modifier in ADDR_W modifier base
- cmd_length in ADDR_W+1 element count
- cmd_cond_sel in SEL_W flag index or COND_ALWAYS
- flags in NUM_FLAGS condition flags, sampled at accept
- rd_a_en/rd_a_addr out 1/ADDR_W origin read
- rd_a_data in DATA_W origin data, 1 cycle after rd_a_en
- rd_b_en/rd_b_addr out 1/ADDR_W modifier read
- rd_b_data in DATA_W modifier data, 1 cycle after rd_b_en
- wr_en/wr_addr/wr_data out 1/ADDR_W/DATA_W write
- busy out 1 not IDLE
- done out 1 one-cycle completion pulse
- done_skipped out 1 qualifies done: condition false
- done_error out 1 qualifies done: range overflow

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Reset: state IDLE; cmd_ready=1; busy, done, done_skipped, done_error, rd_*_en, wr_en = 0; addresses/data = 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: cmd_ready=1. Accept on cmd_valid&&cmd_ready (cycle T). Latch descriptor, flags bit, direction.
- Condition: true if cmd_cond_sel==COND_ALWAYS. Otherwise flags[cmd_cond_sel]. A select >= NUM_FLAGS that is not COND_ALWAYS evaluates false.
- Error: origin+length > 2**ADDR_W or modifier+length > 2**ADDR_W, computed at ADDR_W+1 bits.
- Short paths: if error, or condition false, or length==0 -> DONE at T+1 with no reads or writes. Error takes priority over skipped. done_skipped=1 only for condition false with no error.
- Direction: descending (i = length-1 down to 0) iff modifier < origin; otherwise ascending. This makes an in-flight write never alias a later read, so no stall and no forwarding.
- RUN: reads for element i issue at T+1+k (k = 0..L-1); rd_a_en and rd_b_en are asserted together.
- Write for element i in cycle T+2+k: wr_data = rd_a_data - rd_b_data, modulo 2**DATA_W (wrap, no saturation/flag).
- After the last read issues, go to DRAIN (one cycle, last write), then DONE.
- DONE: done=1 for exactly one cycle (T+L+2 for a full run), then IDLE. cmd_ready=0 in RUN/DRAIN/DONE.
- Store contract: same-cycle read and write of the same address returns old data. Engine never relies on this except modifier==origin, where result is 0 either way.
- flags changes after accept have no effect. cmd_* changes while busy are ignored.
- Reset mid-operation: immediate return to reset values; writes already issued stand; no done pulse.

Decomposition:
- Extend the shared package with:
  - de_state_e enum
  - COND_ALWAYS constant
  - de_cmd_t packed struct (origin, modifier, length, cond_sel), field-compatible with differenceMap_a so the decoder drives it directly.
- One sub-module: de_addr_gen (index counter, direction, last-element detect, address adders).
- Subtract/write stage stays in the top module.

Test Plan:
- Reset, then mem[16..19]={10,20,30,40}, mem[32..35]={1,2,3,4}, origin=16 mod=32 len=4 ALWAYS -> mem[16..19]={9,18,27,36}; done at T+6; wr_en on 4 consecutive cycles.
- Overlap descending: mem[0..4]={5,7,11,13,17}, origin=1 mod=0 len=4 -> mem[1..4]={2,4,2,4}, mem[0]=5 (snapshot values), write addresses 4,3,2,1.
- Underflow and self-operation: mem[8]=0, mem[9]=1, origin=8 mod=9 len=1 -> mem[8]=0xFFFFFFFF. Then origin=mod=20 len=3 -> mem[20..22]=0.
- Condition: sel=3 with flags=0x00 -> done with done_skipped=1 at T+1, no wr_en. Same command with flags=0x08 -> writes occur. flags toggled after accept has no effect.
- Boundary: origin=252 len=4 (ADDR_W=8) executes. origin=253 len=4 -> done_error=1, no writes. len=0 -> done at T+1, no reads.
- Assert rst_n low at T+3 of a len=8 run -> outputs to reset values asynchronously, no done. Next command accepted normally; back-to-back commands held on cmd_valid are accepted only after DONE->IDLE.

Source files
------------

// File: rtl/difference_map_engine_pkg.sv
// Shared types and helpers for the differenceMap_a executor: descriptor layout,
// engine states and the accept-time condition / range evaluation.
package difference_map_engine_pkg;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int NUM_FLAGS  = 8;
  localparam int SEL_W      = 4;
  localparam int FLAG_IDX_W = $clog2(NUM_FLAGS);

  localparam logic [SEL_W-1:0] COND_ALWAYS = '1;
  localparam logic [ADDR_W:0]  STORE_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    DE_IDLE  = 2'd0,
    DE_RUN   = 2'd1,
    DE_DRAIN = 2'd2,
    DE_DONE  = 2'd3
  } de_state_e;

  // Field order matches differenceMap_a so the decoder can drive it directly.
  typedef struct packed {
    logic [ADDR_W-1:0] origin;
    logic [ADDR_W-1:0] modifier;
    logic [ADDR_W:0]   length;
    logic [SEL_W-1:0]  cond_sel;
  } de_cmd_t;

  // Selects outside the flag range (other than COND_ALWAYS) read as false.
  function automatic logic cond_true(input logic [SEL_W-1:0] sel,
                                     input logic [NUM_FLAGS-1:0] flag_vec);
    if (sel == COND_ALWAYS) return 1'b1;
    if (sel < SEL_W'(NUM_FLAGS)) return flag_vec[sel[FLAG_IDX_W-1:0]];
    return 1'b0;
  endfunction

  function automatic logic range_error(input logic [ADDR_W-1:0] origin,
                                       input logic [ADDR_W-1:0] modifier,
                                       input logic [ADDR_W:0]   length);
    return (({1'b0, origin} + length) > STORE_DEPTH) ||
           (({1'b0, modifier} + length) > STORE_DEPTH);
  endfunction

endpackage

// File: rtl/de_addr_gen.sv
// Element walker: latches the descriptor on load, then steps both addresses one
// element per cycle in the chosen direction and flags the final element.
module de_addr_gen
  import difference_map_engine_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  de_cmd_t           cmd,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              last
);

  logic [ADDR_W-1:0] a_q, b_q;
  logic [ADDR_W:0]   remain_q;
  logic              desc_q;
  logic              desc_d;
  logic [ADDR_W-1:0] a_start, b_start;

  // Walking away from the write side keeps every later read ahead of the writes.
  assign desc_d  = cmd.modifier < cmd.origin;
  assign a_start = desc_d ? cmd.origin + cmd.length[ADDR_W-1:0] - ADDR_W'(1) : cmd.origin;
  assign b_start = desc_d ? cmd.modifier + cmd.length[ADDR_W-1:0] - ADDR_W'(1) : cmd.modifier;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      remain_q <= '0;
      desc_q   <= 1'b0;
    end else if (load) begin
      a_q      <= a_start;
      b_q      <= b_start;
      remain_q <= cmd.length;
      desc_q   <= desc_d;
    end else if (step) begin
      a_q      <= desc_q ? a_q - ADDR_W'(1) : a_q + ADDR_W'(1);
      b_q      <= desc_q ? b_q - ADDR_W'(1) : b_q + ADDR_W'(1);
      remain_q <= remain_q - (ADDR_W+1)'(1);
    end
  end

  assign a_addr = a_q;
  assign b_addr = b_q;
  assign last   = (remain_q == (ADDR_W+1)'(1));

endmodule

// File: rtl/difference_map_engine.sv
// Executes one differenceMap_a descriptor against a 2R1W word store, one element
// per cycle: mem[origin+i] -= mem[modifier+i], with snapshot read semantics.
module difference_map_engine
  import difference_map_engine_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_W-1:0]    cmd_origin,
  input  logic [ADDR_W-1:0]    cmd_modifier,
  input  logic [ADDR_W:0]      cmd_length,
  input  logic [SEL_W-1:0]     cmd_cond_sel,
  input  logic [NUM_FLAGS-1:0] flags,
  output logic                 rd_a_en,
  output logic [ADDR_W-1:0]    rd_a_addr,
  input  logic [DATA_W-1:0]    rd_a_data,
  output logic                 rd_b_en,
  output logic [ADDR_W-1:0]    rd_b_addr,
  input  logic [DATA_W-1:0]    rd_b_data,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 done_skipped,
  output logic                 done_error,
  output logic [1:0]           dbg_state
);

  // Handshake: a descriptor transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and cmd_* / flags are ignored at all other times.

  de_state_e         state_q, state_d;
  de_cmd_t           cmd;
  logic              accept, step, last;
  logic              cond_ok, range_err, short_path;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic              skip_q, err_q, wr_pend_q;
  logic [ADDR_W-1:0] wr_addr_q;

  assign cmd        = {cmd_origin, cmd_modifier, cmd_length, cmd_cond_sel};
  assign cond_ok    = cond_true(cmd_cond_sel, flags);
  assign range_err  = range_error(cmd_origin, cmd_modifier, cmd_length);
  assign short_path = range_err || !cond_ok || (cmd_length == '0);

  de_addr_gen u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .step   (step),
    .cmd    (cmd),
    .a_addr (a_addr),
    .b_addr (b_addr),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DE_IDLE;
      skip_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_pend_q <= rd_a_en;
      wr_addr_q <= rd_a_addr;
      if (accept) begin
        err_q  <= range_err;
        skip_q <= !range_err && !cond_ok;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    case (state_q)
      DE_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = short_path ? DE_DONE : DE_RUN;
        end
      end
      DE_RUN: begin
        step = 1'b1;
        if (last) state_d = DE_DRAIN;
      end
      DE_DRAIN: state_d = DE_DONE;
      DE_DONE:  state_d = DE_IDLE;
      default:  state_d = DE_IDLE;
    endcase
  end

  assign rd_a_en   = (state_q == DE_RUN);
  assign rd_b_en   = rd_a_en;
  assign rd_a_addr = rd_a_en ? a_addr : '0;
  assign rd_b_addr = rd_b_en ? b_addr : '0;

  // Store data lands one cycle after the read, so the write trails by one element.
  assign wr_en   = wr_pend_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_pend_q ? rd_a_data - rd_b_data : '0;

  assign busy         = (state_q != DE_IDLE);
  assign done         = (state_q == DE_DONE);
  assign done_skipped = done && skip_q;
  assign done_error   = done && err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_difference_map_engine.sv
// Directed bench for difference_map_engine: word store model, descriptor driver,
// output monitor, and hand-computed expected results.
module tb_difference_map_engine;
  import difference_map_engine_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_origin = '0, cmd_modifier = '0;
  logic [8:0]  cmd_length = '0;
  logic [3:0]  cmd_cond_sel = '0;
  logic [7:0]  flags = '0;
  logic        rd_a_en, rd_b_en, wr_en, busy, done, done_skipped, done_error;
  logic [7:0]  rd_a_addr, rd_b_addr, wr_addr;
  logic [31:0] rd_a_data = '0, rd_b_data = '0, wr_data;
  logic [1:0]  dbg_state;

  difference_map_engine dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_origin(cmd_origin), .cmd_modifier(cmd_modifier),
    .cmd_length(cmd_length), .cmd_cond_sel(cmd_cond_sel), .flags(flags),
    .rd_a_en(rd_a_en), .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
    .rd_b_en(rd_b_en), .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .done_skipped(done_skipped), .done_error(done_error),
    .dbg_state(dbg_state)
  );

  // ---------------- word store (2R1W, old data on same-cycle collision) ----------------
  logic [31:0] mem [256];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_addr = '0;
  logic [31:0] poke_data = '0;

  always @(posedge clk) begin
    if (rd_a_en) rd_a_data <= mem[rd_a_addr];
    if (rd_b_en) rd_b_data <= mem[rd_b_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
    else if (poke_en) mem[poke_addr] <= poke_data;
  end

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         wr_total = 0, rd_total = 0, done_total = 0, pair_bad = 0, last_done_cyc = 0;
  logic       last_skip = 1'b0, last_err = 1'b0;
  logic [7:0] wr_log[$];
  int         wr_cyc_log[$];

  always @(negedge clk) begin
    if (wr_en) begin
      wr_total++;
      wr_log.push_back(wr_addr);
      wr_cyc_log.push_back(cyc);
    end
    if (rd_a_en) rd_total++;
    if (rd_a_en != rd_b_en) pair_bad++;
    if (done) begin
      done_total++;
      last_done_cyc = cyc;
      last_skip = done_skipped;
      last_err = done_error;
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1;
    poke_addr = a;
    poke_data = d;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  int   r_lat, r_wr, r_rd, r_log0, t_acc;
  logic r_skip, r_err;

  task automatic run_cmd(input logic [7:0] o, input logic [7:0] m, input logic [8:0] l,
                         input logic [3:0] s, input logic [7:0] f, input logic [7:0] f_after);
    int d0, w0, r0;
    logic got;
    @(negedge clk);
    d0 = done_total; w0 = wr_total; r0 = rd_total; r_log0 = wr_log.size();
    check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_origin = o; cmd_modifier = m; cmd_length = l; cmd_cond_sel = s; flags = f;
    cmd_valid = 1'b1;
    t_acc = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    flags = f_after;
    cmd_origin = 8'($urandom); cmd_modifier = 8'($urandom);
    cmd_length = 9'($urandom); cmd_cond_sel = 4'($urandom);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (done_total != d0) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", {31'd0, got}, 32'd1);
    r_lat = last_done_cyc - t_acc;
    r_wr = wr_total - w0;
    r_rd = rd_total - r0;
    r_skip = last_skip;
    r_err = last_err;
    @(negedge clk);
    #1;
    check("done_single_pulse", done_total - d0, 32'd1);
  endtask

  // ---------------- directed stimulus ----------------
  int d_base, t1, t2;
  logic got_ready;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {29'd0, done, done_skipped, done_error}, 32'd0);
    check("rst_en", {29'd0, rd_a_en, rd_b_en, wr_en}, 32'd0);
    check("rst_addr", {8'd0, rd_a_addr, rd_b_addr, wr_addr}, 32'd0);
    check("rst_wdata", wr_data, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;

    // Ascending basic run
    poke(16, 10); poke(17, 20); poke(18, 30); poke(19, 40);
    poke(32, 1);  poke(33, 2);  poke(34, 3);  poke(35, 4);
    run_cmd(16, 32, 4, COND_ALWAYS, 8'h00, 8'h00);
    check("t1_lat", r_lat, 6);
    check("t1_wr_cnt", r_wr, 4);
    check("t1_rd_cnt", r_rd, 4);
    check("t1_first_wr_cyc", wr_cyc_log[r_log0] - t_acc, 2);
    check("t1_wr_consec", wr_cyc_log[r_log0+3] - wr_cyc_log[r_log0], 3);
    check("t1_wr_addr0", {24'd0, wr_log[r_log0]}, 16);
    check("t1_m16", mem[16], 9);
    check("t1_m17", mem[17], 18);
    check("t1_m18", mem[18], 27);
    check("t1_m19", mem[19], 36);
    check("t1_flags", {30'd0, r_skip, r_err}, 0);

    // Overlapping, descending walk keeps snapshot semantics
    poke(0, 5); poke(1, 7); poke(2, 11); poke(3, 13); poke(4, 17);
    run_cmd(1, 0, 4, COND_ALWAYS, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) check("t2_wr_addr", {24'd0, wr_log[r_log0+i]}, 32'(4 - i));
    check("t2_m0", mem[0], 5);
    check("t2_m1", mem[1], 2);
    check("t2_m2", mem[2], 4);
    check("t2_m3", mem[3], 2);
    check("t2_m4", mem[4], 4);

    // Underflow wraps; self-operation yields zero
    poke(8, 0); poke(9, 1);
    run_cmd(8, 9, 1, COND_ALWAYS, 8'h00, 8'h00);
    check("t3_lat", r_lat, 3);
    check("t3_m8", mem[8], 32'hFFFF_FFFF);
    poke(20, 32'h1234); poke(21, 32'hDEAD_BEEF); poke(22, 1);
    run_cmd(20, 20, 3, COND_ALWAYS, 8'h00, 8'h00);
    check("t3_m20", mem[20], 0);
    check("t3_m21", mem[21], 0);
    check("t3_m22", mem[22], 0);

    // Condition select
    poke(100, 50); poke(101, 60); poke(110, 5); poke(111, 6);
    run_cmd(100, 110, 2, 4'd3, 8'h00, 8'h08);
    check("t4_skip_lat", r_lat, 1);
    check("t4_skip_flags", {30'd0, r_skip, r_err}, 32'b10);
    check("t4_skip_wr", r_wr, 0);
    check("t4_skip_mem", mem[100], 50);
    run_cmd(100, 110, 2, 4'd9, 8'hFF, 8'hFF);
    check("t4_badsel_skip", {30'd0, r_skip, r_err}, 32'b10);
    run_cmd(100, 110, 2, 4'd3, 8'h08, 8'h00);
    check("t4_take_lat", r_lat, 4);
    check("t4_take_flags", {30'd0, r_skip, r_err}, 0);
    check("t4_take_wr", r_wr, 2);
    check("t4_m100", mem[100], 45);
    check("t4_m101", mem[101], 54);

    // Range boundaries and empty descriptor
    poke(252, 1000); poke(253, 1001); poke(254, 1002); poke(255, 1003);
    for (int i = 0; i < 4; i++) poke(8'(200 + i), 1);
    run_cmd(252, 200, 4, COND_ALWAYS, 8'h00, 8'h00);
    check("t5_edge_err", {31'd0, r_err}, 0);
    check("t5_m252", mem[252], 999);
    check("t5_m255", mem[255], 1002);
    run_cmd(253, 200, 4, COND_ALWAYS, 8'h00, 8'h00);
    check("t5_ovf_lat", r_lat, 1);
    check("t5_ovf_flags", {30'd0, r_skip, r_err}, 32'b01);
    check("t5_ovf_wr", r_wr + r_rd, 0);
    run_cmd(0, 253, 4, 4'd3, 8'h00, 8'h00);
    check("t5_modovf_prio", {30'd0, r_skip, r_err}, 32'b01);
    run_cmd(10, 30, 0, COND_ALWAYS, 8'h00, 8'h00);
    check("t5_len0_lat", r_lat, 1);
    check("t5_len0_rd", r_rd + r_wr, 0);
    check("t5_len0_flags", {30'd0, r_skip, r_err}, 0);

    // Reset in the middle of a run
    for (int i = 0; i < 8; i++) begin
      poke(8'(40 + i), 32'(100 + i));
      poke(8'(60 + i), 32'(i + 1));
    end
    @(negedge clk);
    d_base = done_total;
    cmd_origin = 40; cmd_modifier = 60; cmd_length = 8; cmd_cond_sel = COND_ALWAYS;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_busy", {31'd0, busy}, 0);
    check("mrst_ready", {31'd0, cmd_ready}, 1);
    check("mrst_en", {29'd0, rd_a_en, rd_b_en, wr_en}, 0);
    check("mrst_out", {8'd0, rd_a_addr, wr_addr, wr_data[7:0]}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_no_done", done_total - d_base, 0);
    check("mrst_m40", mem[40], 99);
    check("mrst_m41", mem[41], 101);
    check("mrst_m42", mem[42], 102);

    // Back-to-back: second descriptor held on cmd_valid waits for DONE->IDLE
    poke(50, 7);
    @(negedge clk);
    d_base = done_total;
    cmd_origin = 40; cmd_modifier = 60; cmd_length = 2; cmd_cond_sel = COND_ALWAYS;
    cmd_valid = 1'b1;
    t1 = cyc;
    @(posedge clk);
    #1;
    cmd_origin = 50; cmd_modifier = 60; cmd_length = 1;
    got_ready = 1'b0;
    t2 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got_ready = 1'b1;
        t2 = cyc;
        break;
      end
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("b2b_ready_seen", {31'd0, got_ready}, 1);
    check("b2b_gap", t2 - t1, 5);
    for (int i = 0; i < 40 && done_total - d_base < 2; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("b2b_done_cnt", done_total - d_base, 2);
    check("b2b_m40", mem[40], 98);
    check("b2b_m41", mem[41], 99);
    check("b2b_m50", mem[50], 6);

    check("rd_pair", pair_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
